// File: rtl/booth_mult_pkg.sv
// ============================================================================
// Module  : booth_mult_pkg
// Brief   : Shared types and helpers for the sequential radix-4 Booth multiplier
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit d = (neg ? -1 : +1) * (one ? 1 : two ? 2 : 0)
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  function automatic int booth_steps(input int w);
    return w / 2 + 1;
  endfunction

  function automatic booth_digit_t booth_encode(input logic [2:0] triplet);
    booth_digit_t d;
    d = '0;
    case (triplet)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011:         d.two = 1'b1;
      3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_r4_digit.sv
// ============================================================================
// Module  : booth_r4_digit
// Brief   : Selects the signed Booth multiple (0, +-1, +-2) * a_ext for a triplet
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_r4_digit
  import booth_mult_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [2:0]   triplet,
  input  logic [W+1:0] a_ext,
  output logic [W+2:0] multiple
);

  booth_digit_t digit;
  logic [W+2:0] mag;

  always_comb begin
    digit = booth_encode(triplet);
    mag   = '0;
    if (digit.one) begin
      mag = {a_ext[W+1], a_ext};
    end else if (digit.two) begin
      mag = {a_ext, 1'b0};
    end
    multiple = digit.neg ? -mag : mag;
  end

endmodule

`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
// ============================================================================
// Module  : booth_r4_seq_mult
// Brief   : Sequential radix-4 Booth multiplier, one digit per clock, valid/ready
//           handshakes. Optional macro BOOTH_MULT_EARLY_TERM_EN ends the
//           computation once all remaining Booth digits are zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_r4_seq_mult
  import booth_mult_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           busy
);

  localparam int N  = booth_steps(W);
  localparam int CW = $clog2(N + 1);

  state_t          state;
  state_t          state_nxt;
  logic [W+1:0]    a_ext;
  logic [W+2:0]    b_sh;       // {unprocessed b_ext bits, lookback bit}
  logic [2*W+3:0]  acc;
  logic [CW-1:0]   step;
  logic [W+2:0]    multiple;
  logic [2*W+3:0]  partial;
  logic [2*W+3:0]  acc_nxt;
  logic            accept;
  logic            last_step;
  logic            step_done;

  booth_r4_digit #(.W(W)) u_digit (
    .triplet  (b_sh[2:0]),
    .a_ext    (a_ext),
    .multiple (multiple)
  );

  assign accept    = in_valid & in_ready;
  assign last_step = (step == CW'(N - 1));
  assign partial   = {{(W + 1){multiple[W+2]}}, multiple} << {step, 1'b0};
  assign acc_nxt   = acc + partial;

`ifdef BOOTH_MULT_EARLY_TERM_EN
  // b_sh is shifted arithmetically, so bits above the live window already
  // equal the extension bit; uniform [W+2:2] means every later digit is 0.
  logic rest_uniform;
  assign rest_uniform = (&b_sh[W+2:2]) | ~(|b_sh[W+2:2]);
  assign step_done    = last_step | rest_uniform;
`else
  assign step_done    = last_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)    state_nxt = ST_CALC;
      ST_CALC: if (step_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Flags are decoded from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
      busy      <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_ext  <= '0;
      b_sh   <= '0;
      acc    <= '0;
      step   <= '0;
      result <= '0;
    end else if (accept) begin
      a_ext <= is_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
      b_sh  <= is_signed ? {{2{b[W-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
      acc   <= '0;
      step  <= '0;
    end else if (state == ST_CALC) begin
      acc  <= acc_nxt;
      b_sh <= {{2{b_sh[W+2]}}, b_sh[W+2:2]};
      step <= step + CW'(1);
      if (step_done) begin
        result <= acc_nxt[2*W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
// ============================================================================
// Module  : tb_booth_r4_seq_mult
// Brief   : Self-checking bench: directed corners plus randomized handshakes
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_r4_seq_mult;

  localparam int W = 16;
  localparam int N = W / 2 + 1;
`ifdef BOOTH_MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          is_signed;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] result;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  booth_r4_seq_mult #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [63:0] xe, ye, p;
    xe = s ? {{48{x[15]}}, x} : {48'b0, x};
    ye = s ? {{48{y[15]}}, y} : {48'b0, y};
    p  = xe * ye;
    return p[31:0];
  endfunction

  // Steps performed: with early termination, stop after the first step whose
  // remaining multiplier bits (plus the lookback bit) are all equal.
  function automatic int exp_steps(input logic [15:0] y, input logic s);
    logic [17:0] be;
    int k;
    be = s ? {{2{y[15]}}, y} : {2'b00, y};
    k  = N;
    for (int i = N - 1; i >= 0; i--) begin
      bit eq;
      eq = 1'b1;
      for (int j = 2 * i + 1; j <= 17; j++) begin
        if (be[j] != be[17]) eq = 1'b0;
      end
      if (eq) k = i + 1;
    end
    return ET ? k : N;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic scramble(input bit noise);
    in_valid  = noise ? 1'($urandom) : 1'b0;
    a         = 16'($urandom);
    b         = 16'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                        input logic ts, input int stall, input bit noise);
    logic [31:0] exp;
    int lat, exp_lat, guard;
    exp     = ref_mul(ta, tbv, ts);
    exp_lat = exp_steps(tbv, ts) + 1;
    guard   = 0;
    while (!in_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check({tag, "_rdy_timeout"}, 64'(in_ready), 64'd1);
      return;
    end
    a         = ta;
    b         = tbv;
    is_signed = ts;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    lat = 1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_rdy_low"}, 64'(in_ready), 64'd0);
    scramble(noise);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      scramble(noise);
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), 64'(exp));
    for (int s = 0; s < stall; s++) begin
      in_valid = noise;
      @(negedge clk);
      check({tag, "_stall_ov"}, 64'(out_valid), 64'd1);
      check({tag, "_stall_res"}, 64'(result), 64'(exp));
      check({tag, "_stall_rdy"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
    check({tag, "_hold"}, 64'(result), 64'(exp));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy_after", 64'(in_ready), 64'd1);

    run_op("s_m3x7",   16'hFFFD, 16'h0007, 1'b1, 0, 1'b0);
    run_op("u_ffff",   16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op("s_min2",   16'h8000, 16'h8000, 1'b1, 0, 1'b0);
    run_op("s_maxmin", 16'h7FFF, 16'h8000, 1'b1, 0, 1'b0);
    run_op("bp5",      16'h1234, 16'hABCD, 1'b1, 5, 1'b1);
    run_op("s_5x3",    16'h0005, 16'h0003, 1'b1, 0, 1'b0);
    run_op("s_5x0",    16'h0005, 16'h0000, 1'b1, 0, 1'b0);

    // Reset asserted during the 4th CALC cycle drops the operation.
    a = 16'h00FF; b = 16'h0F0F; is_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ov", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_res", 64'(result), 64'd0);
    check("mid_rst_rdy", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rdy_after", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", 64'(seen), 64'd0);

    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op("rnd", pick(), pick(), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
